// File: rtl/regport_arbiter.sv
// Two-requester register-file write-port arbiter with alternating tie priority,
// one-cycle registered write outputs and a saturating contention counter.
// Optional combinational forwarding ports are enabled by defining REGARB_FWD_EN.
module regport_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              regWrite,
    output logic [ADDR_W-1:0] regWaddr,
    output logic [DATA_W-1:0] data,
    output logic              last_b,
    output logic [CNT_W-1:0]  contention
`ifdef REGARB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on whether the requester will keep valid.
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] regwaddr_q, regwaddr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_b_q, last_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // On a tie the requester that did not win the previous grant goes next.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst && !stall) begin
            if (a_valid && (!b_valid || last_b_q)) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    always_comb begin
        regwrite_d = 1'b0;
        regwaddr_d = regwaddr_q;
        data_d     = data_q;
        last_b_d   = last_b_q;
        cnt_d      = cnt_q;
        if (a_ready) begin
            regwaddr_d = a_addr;
            data_d     = a_data;
            regwrite_d = |a_addr;
            last_b_d   = 1'b0;
        end else if (b_ready) begin
            regwaddr_d = b_addr;
            data_d     = b_data;
            regwrite_d = |b_addr;
            last_b_d   = 1'b1;
        end
        // Counts raw overlap of requests, stalled or not, and sticks at all-ones.
        if (a_valid && b_valid && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            regwaddr_q <= '0;
            data_q     <= '0;
            last_b_q   <= 1'b1;
            cnt_q      <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            regwaddr_q <= regwaddr_d;
            data_q     <= data_d;
            last_b_q   <= last_b_d;
            cnt_q      <= cnt_d;
        end
    end

    assign regWrite   = regwrite_q;
    assign regWaddr   = regwaddr_q;
    assign data       = data_q;
    assign last_b     = last_b_q;
    assign contention = cnt_q;

`ifdef REGARB_FWD_EN
    assign fwd_hit  = regwrite_q && (fwd_addr == regwaddr_q);
    assign fwd_data = data_q;
`endif

endmodule
